// File: rtl/uart_sched_pkg.sv
// -----------------------------------------------------------------------------
// uart_sched_pkg
// Shared definitions for the UART transmit scheduler:
//   - sched_state_t : scheduler FSM encoding (3 bits)
//   - UART_BYTE_W   : width of one UART payload byte
//   - TIMEOUT_CYC   : cycles allowed for the serializer to raise busy
//                     (used only when UART_SCHED_TIMEOUT_EN is defined)
// -----------------------------------------------------------------------------
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_ARB       = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } sched_state_t;

    localparam int UART_BYTE_W = 8;
    localparam int TIMEOUT_CYC = 4;

endpackage

// File: rtl/uart_tx_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// uart_rr_arbiter
// Combinational rotate-priority pick. The search starts one position above
// i_rr_ptr and wraps, so the last served requester gets lowest priority.
// Ports:
//   i_req       in   NUM_REQ  request vector
//   i_rr_ptr    in   IDX_W    index of the most recently served requester
//   o_winner    out  IDX_W    selected requester (0 when none)
//   o_any_valid out  1        at least one request present
// -----------------------------------------------------------------------------
module uart_rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_valid
);

    int w_idx;

    always_comb begin
        o_winner    = '0;
        o_any_valid = 1'b0;
        w_idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_rr_ptr) + k) % NUM_REQ;
            if (!o_any_valid && i_req[w_idx]) begin
                o_any_valid = 1'b1;
                o_winner    = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one 8N1 UART serializer among NUM_REQ byte requesters with
// round-robin arbitration, packet locking (bounded by LOCK_MAX bytes) and
// GAP_BITS idle bit-times after each frame. Runs on the bit-rate clock.
//
// Optional feature macro: UART_SCHED_TIMEOUT_EN
//   When defined, WAIT_BUSY gives up after TIMEOUT_CYC cycles without tx_busy,
//   pulses tx_timeout and returns to arbitration (the byte stays acked).
//
// Ports:
//   clk_inside  in   1            bit-rate clock
//   rst_n       in   1            asynchronous active-low reset
//   req         in   NUM_REQ      per-requester byte valid (held until acked)
//   req_last    in   NUM_REQ      current byte ends its packet
//   req_data    in   8*NUM_REQ    requester i byte on [8i+7:8i]
//   req_ack     out  NUM_REQ      one-hot one-cycle accept pulse
//   tx_start    out  1            one-cycle start pulse to the serializer
//   tx_data     out  8            byte to the serializer
//   tx_busy     in   1            serializer busy (start bit .. stop bit)
//   grant_id    out  IDX_W        current/last granted requester
//   sched_busy  out  1            high whenever not arbitrating
//   tx_timeout  out  1            (UART_SCHED_TIMEOUT_EN only) timeout pulse
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int GAP_BITS = 3,
    parameter int LOCK_MAX = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                           clk_inside,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic                           tx_start,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic [IDX_W-1:0]               grant_id,
    output logic                           sched_busy
`ifdef UART_SCHED_TIMEOUT_EN
   ,output logic                           tx_timeout
`endif
);

    sched_state_t             r_state;
    sched_state_t             w_state_nxt;

    logic                     r_lock;
    logic [7:0]               r_byte_cnt;
    logic [IDX_W-1:0]         r_rr_ptr;
    logic [IDX_W-1:0]         r_grant_id;
    logic [3:0]               r_gap_cnt;
    logic                     r_tx_start;
    logic [UART_BYTE_W-1:0]   r_tx_data;
    logic [NUM_REQ-1:0]       r_req_ack;

    logic [IDX_W-1:0]         w_arb_winner;
    logic                     w_arb_valid;
    logic                     w_lock_hit;
    logic [IDX_W-1:0]         w_winner;
    logic                     w_win_valid;
    logic [UART_BYTE_W-1:0]   w_sel_data;
    logic                     w_sel_last;
    logic [8:0]               w_byte_cnt_inc;
    logic                     w_lock_keep;

`ifdef UART_SCHED_TIMEOUT_EN
    logic [2:0]               r_wait_cnt;
    logic                     w_timeout;
`endif

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req       (req),
        .i_rr_ptr    (r_rr_ptr),
        .o_winner    (w_arb_winner),
        .o_any_valid (w_arb_valid)
    );

    // A locked owner with its next byte ready bypasses the rotating search.
    // If the owner has dropped req, the search below takes over this cycle.
    assign w_lock_hit     = r_lock && req[r_grant_id];
    assign w_winner       = w_lock_hit ? r_grant_id : w_arb_winner;
    assign w_win_valid    = w_lock_hit || w_arb_valid;

    assign w_sel_data     = req_data[int'(r_grant_id)*UART_BYTE_W +: UART_BYTE_W];
    assign w_sel_last     = req_last[r_grant_id];
    assign w_byte_cnt_inc = {1'b0, r_byte_cnt} + 9'd1;
    // Keep the grant only mid-packet and while the byte budget lasts.
    assign w_lock_keep    = !w_sel_last && (w_byte_cnt_inc < 9'(LOCK_MAX));

`ifdef UART_SCHED_TIMEOUT_EN
    // First WAIT_BUSY cycle is the one in which tx_start is visible.
    assign w_timeout = (r_state == ST_WAIT_BUSY) && !tx_busy &&
                       (r_wait_cnt == 3'(TIMEOUT_CYC - 1));
`endif

    // State register
    always_ff @(posedge clk_inside or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_win_valid) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
`ifdef UART_SCHED_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = ST_ARB;
                end
`endif
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = (GAP_BITS == 0) ? ST_ARB : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // Grant, lock, counters and registered serializer handshake
    always_ff @(posedge clk_inside or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_byte_cnt <= 8'd0;
            r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_gap_cnt  <= 4'd0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_req_ack  <= '0;
`ifdef UART_SCHED_TIMEOUT_EN
            r_wait_cnt <= 3'd0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_req_ack  <= '0;
            case (r_state)
                ST_ARB: begin
                    if (r_lock && !req[r_grant_id]) begin
                        r_lock     <= 1'b0;
                        r_byte_cnt <= 8'd0;
                    end
                    if (w_win_valid) begin
                        r_grant_id <= w_winner;
                    end
                end
                ST_LOAD: begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= w_sel_data;
                    r_req_ack  <= NUM_REQ'(1) << r_grant_id;
                    r_lock     <= w_lock_keep;
                    if (w_lock_keep) begin
                        r_byte_cnt <= w_byte_cnt_inc[7:0];
                    end else begin
                        // Releasing the grant: the owner drops to lowest priority.
                        r_byte_cnt <= 8'd0;
                        r_rr_ptr   <= r_grant_id;
                    end
`ifdef UART_SCHED_TIMEOUT_EN
                    r_wait_cnt <= 3'd0;
`endif
                end
                ST_WAIT_BUSY: begin
`ifdef UART_SCHED_TIMEOUT_EN
                    r_wait_cnt <= r_wait_cnt + 3'd1;
                    if (w_timeout) begin
                        r_lock     <= 1'b0;
                        r_byte_cnt <= 8'd0;
                        r_rr_ptr   <= r_grant_id;
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy && (GAP_BITS != 0)) begin
                        r_gap_cnt <= 4'(GAP_BITS - 1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt != 4'd0) begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        sched_busy = (r_state != ST_ARB);
        tx_start   = r_tx_start;
        tx_data    = r_tx_data;
        req_ack    = r_req_ack;
        grant_id   = r_grant_id;
`ifdef UART_SCHED_TIMEOUT_EN
        tx_timeout = w_timeout;
`endif
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Requesters hold byte queues; a packet-level reference model turns the loaded
// queues into the expected serializer byte order, and a monitor compares each
// grant/ack/tx_start against that order. A behavioural serializer stays busy
// for a 10-bit frame after each tx_start.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int GAP_BITS = 3;
    localparam int LOCK_MAX = 3;
    localparam int FRAME    = 10;
    localparam int IDX_W    = $clog2(NUM_REQ);

    logic                   clk_inside;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     req_last;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_ack;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic                   tx_busy;
    logic [IDX_W-1:0]       grant_id;
    logic                   sched_busy;

    uart_tx_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .GAP_BITS (GAP_BITS),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk_inside (clk_inside),
        .rst_n      (rst_n),
        .req        (req),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .sched_busy (sched_busy)
    );

    initial begin
        clk_inside = 1'b0;
        forever #5 clk_inside = ~clk_inside;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Requester side: {last, data} per byte
    logic [8:0]  rq [NUM_REQ][$];
    // Reference model input copy and expected {id, data} output order
    logic [8:0]  mq [NUM_REQ][$];
    logic [15:0] exp_q [$];
    int          m_rr;
    int          m_owner;
    int          m_cnt;
    bit          m_lock;

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() > 0) begin
                req[i]          = 1'b1;
                req_last[i]     = rq[i][0][8];
                req_data[8*i+:8] = rq[i][0][7:0];
            end else begin
                req[i]          = 1'b0;
                req_last[i]     = 1'b0;
                req_data[8*i+:8] = 8'h00;
            end
        end
    endtask

    task automatic load_byte(input int id, input logic [7:0] d, input bit last);
        rq[id].push_back({last, d});
        mq[id].push_back({last, d});
    endtask

    task automatic load_pkt(input int id, input int len);
        for (int k = 0; k < len; k++) begin
            load_byte(id, 8'($urandom), (k == len - 1));
        end
    endtask

    task automatic model_reset();
        m_rr    = NUM_REQ - 1;
        m_owner = 0;
        m_cnt   = 0;
        m_lock  = 0;
    endtask

    // Packet-level scheduling: owner continues its packet for at most LOCK_MAX
    // bytes; otherwise the next non-empty requester after the last one served.
    task automatic model_run();
        int         w;
        int         j;
        logic [8:0] b;
        while (1) begin
            w = -1;
            if (m_lock && mq[m_owner].size() > 0) begin
                w = m_owner;
            end else begin
                m_lock = 0;
                m_cnt  = 0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    j = (m_rr + k) % NUM_REQ;
                    if (w < 0 && mq[j].size() > 0) w = j;
                end
            end
            if (w < 0) break;
            b = mq[w].pop_front();
            exp_q.push_back({w[7:0], b[7:0]});
            m_cnt++;
            if (b[8] || m_cnt >= LOCK_MAX) begin
                m_lock = 0;
                m_rr   = w;
                m_cnt  = 0;
            end else begin
                m_lock  = 1;
                m_owner = w;
            end
        end
    endtask

    // Behavioural serializer
    int         ser_cnt;
    logic [7:0] ser_byte;
    initial begin
        tx_busy  = 1'b0;
        ser_cnt  = 0;
        ser_byte = 8'h00;
        forever begin
            @(negedge clk_inside);
            if (!rst_n) begin
                ser_cnt = 0;
                tx_busy = 1'b0;
            end else if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    check("tx_data_hold", tx_data, ser_byte);
                    tx_busy = 1'b0;
                end
            end else if (tx_start) begin
                ser_byte = tx_data;
                tx_busy  = 1'b1;
                ser_cnt  = FRAME;
            end
        end
    end

    // Monitor
    logic [15:0] mon_e;
    initial begin
        forever begin
            @(posedge clk_inside);
            #1;
            if (rst_n && (tx_start || req_ack != '0)) begin
                check("tx_start_with_ack", tx_start, 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", req_ack, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grant_id", grant_id, mon_e[15:8]);
                    check("tx_data", tx_data, mon_e[7:0]);
                    check("req_ack", req_ack, 32'd1 << mon_e[15:8]);
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ack[i] && rq[i].size() > 0) rq[i].delete(0);
                end
                drive_reqs();
            end
        end
    end

    task automatic tick();
        @(posedge clk_inside);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (n < budget && !(exp_q.size() == 0 && !sched_busy && !tx_busy));
        check("drained", exp_q.size(), 0);
    endtask

    task automatic run_loaded(input int budget);
        model_run();
        drive_reqs();
        wait_idle(budget);
    endtask

    int n;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_last = '0;
        req_data = '0;
        model_reset();
        repeat (3) tick();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ack", req_ack, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_sched_busy", sched_busy, 0);
        @(negedge clk_inside);
        rst_n = 1'b1;
        tick();

        // Single request: latency and inter-frame gap
        load_byte(0, 8'h41, 1'b1);
        model_run();
        drive_reqs();
        tick();
        check("lat_edge1_ack", req_ack, 0);
        tick();
        check("lat_edge2_ack", req_ack, 1);
        check("lat_edge2_start", tx_start, 1);
        check("lat_edge2_data", tx_data, 8'h41);
        n = 0;
        while (!tx_busy && n < 40) begin tick(); n++; end
        n = 0;
        while (tx_busy && n < 40) begin tick(); n++; end
        n = 0;
        while (sched_busy && n < 40) begin tick(); n++; end
        check("gap_cycles", n, GAP_BITS);
        wait_idle(200);

        // All requesters, single-byte packets, two rotations
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) load_byte(i, 8'($urandom), 1'b1);
        end
        run_loaded(1000);

        // Locked 3-byte packet with a competing requester
        load_pkt(1, 3);
        load_pkt(2, 1);
        run_loaded(500);

        // Packet longer than LOCK_MAX interleaves with another requester
        load_pkt(0, 5);
        load_pkt(3, 1);
        run_loaded(800);

        // Reset during WAIT_DONE while requester 1 holds a lock
        load_byte(1, 8'hA5, 1'b0);
        load_byte(1, 8'h5A, 1'b0);
        load_byte(1, 8'h3C, 1'b1);
        load_pkt(3, 1);
        model_run();
        drive_reqs();
        n = 0;
        while (!tx_busy && n < 60) begin tick(); n++; end
        check("pre_reset_busy", tx_busy, 1);
        @(negedge clk_inside);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_req_ack", req_ack, 0);
        check("mid_rst_grant_id", grant_id, 0);
        check("mid_rst_sched_busy", sched_busy, 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            rq[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
        drive_reqs();
        model_reset();
        repeat (3) tick();
        check("in_rst_req_ack", req_ack, 0);
        @(negedge clk_inside);
        rst_n = 1'b1;
        tick();
        load_byte(1, 8'h11, 1'b0);
        load_byte(1, 8'h12, 1'b1);
        load_byte(0, 8'h20, 1'b1);
        run_loaded(500);

        // Randomized traffic
        for (int s = 0; s < 10; s++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(3) != 0) begin
                    for (int p = 0; p < int'($urandom_range(2, 1)); p++) begin
                        load_pkt(i, int'($urandom_range(5, 1)));
                    end
                end
            end
            run_loaded(3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one 8N1 UART bit-serializer among NUM_REQ byte requesters.
- Round-robin arbitration.
- Packet locking: a requester keeps the grant until its last byte, bounded by LOCK_MAX.
- Inserts GAP_BITS idle bit-times between frames.
- Runs in the bit-rate clock domain and drives the serializer's start/data/busy handshake.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_BITS, 3, idle bit-times inserted after each frame (0..15)
LOCK_MAX, 16, maximum consecutive bytes per grant before forced rotation (1..255)

Ports:
clk_inside  input  1  bit-rate clock, one cycle per UART bit
rst_n  input  1  reset, asynchronous, active-low
req  input  NUM_REQ  per-requester byte-valid; held until acked
req_last  input  NUM_REQ  per-requester marker: current byte ends its packet
req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_ack  output  NUM_REQ  one-hot, one-cycle pulse: byte i accepted
tx_start  output  1  one-cycle pulse to the serializer
tx_data  output  8  byte to the serializer, stable from tx_start until tx_busy falls
tx_busy  input  1  serializer busy, from start bit through stop bit
grant_id  output  $clog2(NUM_REQ)  current/last granted requester
sched_busy  output  1  high in every state except ARB

Behaviour:
- Reset values (async, immediate): tx_start=0, tx_data=8'h00, req_ack=0, grant_id=0, sched_busy=0, state=ARB, lock=0, byte_cnt=0, rr_ptr=NUM_REQ-1 (first priority goes to requester 0).
- States: ARB, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- ARB, winner selection:
  - If lock=1 and req[grant_id]=1: winner is grant_id.
  - If lock=1 and req[grant_id]=0: clear lock and byte_cnt, then fall to round-robin in the same cycle.
  - Round-robin: first set bit of req scanning from rr_ptr+1 upward, with wrap-around.
- ARB, transition: on a winner, register grant_id=winner and go to LOAD. With no req, stay in ARB.
- LOAD (one cycle):
  - tx_data<=req_data[grant_id]; tx_start=1; req_ack[grant_id]=1, all in the same cycle.
  - byte_cnt<=byte_cnt+1.
  - lock<=~req_last[grant_id] && (byte_cnt+1<LOCK_MAX).
  - When lock is cleared here: rr_ptr<=grant_id and byte_cnt<=0.
  - Go to WAIT_BUSY.
- WAIT_BUSY: on tx_busy=1, go to WAIT_DONE.
- WAIT_DONE: on tx_busy=0:
  - GAP_BITS=0: go to ARB.
  - Otherwise: load gap_cnt=GAP_BITS-1 and go to GAP.
- GAP: decrement gap_cnt each cycle; at 0, go to ARB. Result is exactly GAP_BITS cycles in GAP.
- Latency: req rising in ARB gives req_ack and tx_start on the 2nd clk_inside edge.
- Back-to-back frames are separated by the serializer stop bit + GAP_BITS + 2 cycles (ARB, LOAD).
- Requester contract: req, req_last and req_data must not change until acked. If req drops without an ack, the scheduler ignores it; no byte is lost or duplicated.
- Simultaneous requests: a locked owner always wins. Unlocked ties resolve by rotating priority only.
- LOCK_MAX reached: lock clears even if req_last=0. The owner re-arbitrates with lowest priority and its packet resumes later, interleaved with other requesters.
- Asserting rst_n mid-frame:
  - All outputs return to reset values at once and any held lock is dropped.
  - The serializer is reset separately.
  - No req_ack is issued for an unfinished byte.
- grant_id holds its value through idle periods.

Optional Feature:
UART_SCHED_TIMEOUT_EN:
- Defined:
  - WAIT_BUSY counts cycles. If tx_busy is not seen within 4 cycles after tx_start, go to ARB.
  - Pulse the extra output port tx_timeout (1 bit) for one cycle.
  - Clear lock and set rst_ptr... precisely: clear lock and set rr_ptr<=grant_id.
  - The byte stays acked; it is not retried.
- Undefined: the port is absent and WAIT_BUSY waits indefinitely.

Decomposition:
- Package uart_sched_pkg holds:
  - the state encoding (ARB=0, LOAD=1, WAIT_BUSY=2, WAIT_DONE=3, GAP=4, 3-bit);
  - UART_BYTE_W=8;
  - TIMEOUT_CYC=4.
- One sub-module, uart_rr_arbiter: combinational rotate-priority pick.
  - Inputs: req, rr_ptr.
  - Outputs: winner index, any_valid.
  - Reused by the scheduler's ARB state.

Test Plan:
1. Single request: req[0]=1, data 8'h41, req_last=1, GAP_BITS=3, serializer busy 10 cycles → ack[0]/tx_start on 2nd edge, tx_data=8'h41, next ARB exactly 3 cycles after busy falls.
2. All four requesters hold req, each req_last=1 → grant order 0,1,2,3,0; each requester acked once per rotation.
3. req[1] sends 3-byte packet (last on 3rd) while req[2] also pending → bytes 1,1,1 sent contiguously, then requester 2.
4. LOCK_MAX=2, req[0] packet of 5 bytes, req[3] pending → order 0,0,3,0,0,0 (rotation forced after 2).
5. Reset asserted during WAIT_DONE with lock held → outputs zero immediately; after release, first grant goes to requester 0 regardless of prior owner.
6. (UART_SCHED_TIMEOUT_EN) tx_busy held 0 after tx_start → tx_timeout pulse on 4th cycle, state ARB, next requester granted.
